// File: rtl/instr_decode_stage_pkg.sv
// Shared opcode constants, decoded-field bundle and immediate assembly for the decode stage.
// Used by instr_decode_comb and instr_decode_stage.
package instr_decode_stage_pkg;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_FENCE   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       rs1_en;
        logic       rs2_en;
        logic       rd_we;
        logic       illegal;
    } dec_fields_t;

    // Immediate as a 32-bit signed value; the caller widens it to XLEN.
    function automatic logic [31:0] imm32(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] v;
        case (fmt)
            FMT_I:   v = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_J:   v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_U:   v = {instr[31:12], 12'b0};
            default: v = 32'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master = surrounding pipeline, slave = decode stage.
interface instr_decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_we;
    logic            illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, rs1, rs2, rd, opcode,
               funct3, funct7, imm, rs1_en, rs2_en, rd_we, illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_instr, rs1, rs2, rd, opcode,
               funct3, funct7, imm, rs1_en, rs2_en, rd_we, illegal
    );
endinterface

// File: rtl/instr_decode_comb.sv
// Purely combinational RV32I/RV64I field decode, legality check and immediate generation.
module instr_decode_comb
    import instr_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output dec_fields_t     fields,
    output logic [XLEN-1:0] imm
);
    localparam bit RV64 = (XLEN == 64);

    logic [2:0] f3;
    logic [6:0] f7;
    logic       r_bad;
    logic       use_rs1;
    logic       use_rs2;
    logic       use_rd;
    logic       bad;
    imm_fmt_e   fmt;

    assign f3 = instr[14:12];
    assign f7 = instr[31:25];
    assign r_bad = !(f7 == 7'b0000000 || f7 == 7'b0100000) ||
                   (f7 == 7'b0100000 && !(f3 == 3'b000 || f3 == 3'b101));

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        bad     = 1'b0;
        fmt     = FMT_NONE;
        case (instr[6:0])
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                bad = r_bad;
            end
            OPC_OP32: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                bad = !RV64 || r_bad;
            end
            OPC_OPIMM: begin
                use_rs1 = 1'b1; use_rd = 1'b1; fmt = FMT_I;
                // shamt[5] only exists on RV64
                bad = !RV64 && instr[25] && (f3 == 3'b001 || f3 == 3'b101);
            end
            OPC_OPIMM32: begin
                use_rs1 = 1'b1; use_rd = 1'b1; fmt = FMT_I;
                bad = !RV64;
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1; use_rd = 1'b1; fmt = FMT_I;
                bad = (f3 == 3'b111) || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = FMT_S;
                bad = f3[2] || (!RV64 && f3 == 3'b011);
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = FMT_B;
                bad = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LUI, OPC_AUIPC: begin
                use_rd = 1'b1; fmt = FMT_U;
            end
            OPC_JAL: begin
                use_rd = 1'b1; fmt = FMT_J;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1; use_rd = 1'b1; fmt = FMT_I;
                bad = (f3 != 3'b000);
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: bad = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) bad = 1'b1;

        fields         = '0;
        fields.rs1     = instr[19:15];
        fields.rs2     = instr[24:20];
        fields.rd      = instr[11:7];
        fields.opcode  = instr[6:0];
        fields.funct3  = f3;
        fields.funct7  = f7;
        fields.rs1_en  = use_rs1 && !bad;
        fields.rs2_en  = use_rs2 && !bad;
        fields.rd_we   = use_rd && !bad && (instr[11:7] != 5'd0);
        fields.illegal = bad;
        imm = bad ? '0 : XLEN'($signed(imm32(instr, fmt)));
    end
endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: decodes on the input path, holds results in an output
// register plus one skid entry so in_ready depends only on registered state and flush.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    instr_decode_stage_if.slave  bus
);
    dec_fields_t     dec_f;
    logic [XLEN-1:0] dec_imm;

    dec_fields_t     out_f,     skid_f;
    logic [XLEN-1:0] out_imm,   skid_imm;
    logic [PC_W-1:0] out_pc,    skid_pc;
    logic [31:0]     out_instr, skid_instr;
    logic            out_valid, skid_valid;
    logic            out_free;

    instr_decode_comb #(.XLEN(XLEN)) u_dec (
        .instr  (bus.in_instr),
        .fields (dec_f),
        .imm    (dec_imm)
    );

    assign bus.in_ready = ~skid_valid & ~flush;
    assign out_free     = ~out_valid | bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_f      <= '0;
            out_imm    <= '0;
            out_pc     <= '0;
            out_instr  <= '0;
            skid_f     <= '0;
            skid_imm   <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (out_free) begin
                out_f      <= skid_f;
                out_imm    <= skid_imm;
                out_pc     <= skid_pc;
                out_instr  <= skid_instr;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end
        end else if (bus.in_valid) begin
            if (out_free) begin
                out_f     <= dec_f;
                out_imm   <= dec_imm;
                out_pc    <= bus.in_pc;
                out_instr <= bus.in_instr;
                out_valid <= 1'b1;
            end else begin
                skid_f     <= dec_f;
                skid_imm   <= dec_imm;
                skid_pc    <= bus.in_pc;
                skid_instr <= bus.in_instr;
                skid_valid <= 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_pc    = out_pc;
    assign bus.out_instr = out_instr;
    assign bus.rs1       = out_f.rs1;
    assign bus.rs2       = out_f.rs2;
    assign bus.rd        = out_f.rd;
    assign bus.opcode    = out_f.opcode;
    assign bus.funct3    = out_f.funct3;
    assign bus.funct7    = out_f.funct7;
    assign bus.imm       = out_imm;
    assign bus.rs1_en    = out_f.rs1_en;
    assign bus.rs2_en    = out_f.rs2_en;
    assign bus.rd_we     = out_f.rd_we;
    assign bus.illegal   = out_f.illegal;
endmodule
